// File: rtl/map_ram_arbiter_pkg.sv
// rtl/map_ram_arbiter_pkg.sv - shared tile codes, map dimensions and arbiter state encoding
//
// Purpose: common definitions for the tile-map RAM arbiter and its RAM.
// Ports:   none (package).

package map_ram_arbiter_pkg;

  localparam int TILE_W    = 3;
  localparam int MAP_W     = 15;
  localparam int MAP_H     = 13;
  localparam int MAP_TILES = MAP_W * MAP_H;

  typedef enum logic [TILE_W-1:0] {
    TILE_EMPTY       = 3'd0,
    TILE_UNBREAKABLE = 3'd1,
    TILE_BREAKABLE   = 3'd2,
    TILE_BOMB        = 3'd3,
    TILE_EXPLOSION   = 3'd4
  } tile_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } arb_state_t;

endpackage

// File: rtl/map_ram_arbiter_ram.sv
// rtl/map_ram_arbiter_ram.sv - single-port synchronous tile-map RAM
//
// Purpose: DEPTH x DW single-port RAM with a one-cycle registered read.
//          Accesses outside 0..DEPTH-1 never write and read back zero.
// Ports:
//   sys_clk  in   clock
//   en       in   access enable
//   we       in   1 = write, 0 = read
//   addr     in   tile address
//   wdata    in   write data
//   rdata    out  read data, valid the cycle after a read access

module map_ram_arbiter_ram #(
  parameter int AW    = 8,
  parameter int DW    = 3,
  parameter int DEPTH = 195
) (
  input  logic          sys_clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          in_range;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  // No reset: map contents survive Reset by design.
  always_ff @(posedge sys_clk) begin
    if (en) begin
      if (we) begin
        if (in_range) mem[addr] <= wdata;
      end else begin
        rdata <= in_range ? mem[addr] : '0;
      end
    end
  end

endmodule

// File: rtl/map_ram_arbiter.sv
// rtl/map_ram_arbiter.sv - tile-map RAM owner: display-priority / round-robin arbiter plus clear sequence
//
// Purpose: one RAM access per cycle. The display fetch port wins unless it has
//          taken DISP_MAX_BURST grants in a row while game logic waits; game
//          requesters share the rest round-robin. clear_start rewrites every
//          tile with CLEAR_VAL, one per cycle.
// Ports:
//   sys_clk, Reset          clock, asynchronous active-high reset
//   req/we/addr/wdata       game requests (packed per requester), held until ack
//   ack, rdata              one-cycle completion pulse, shared game read data
//   disp_req, disp_addr     display fetch
//   disp_valid, disp_rdata  display read data, one cycle after an accepted fetch
//   disp_stall              this cycle's disp_req was refused
//   clear_start, clear_busy start / status of the clear sequence

module map_ram_arbiter
  import map_ram_arbiter_pkg::*;
#(
  parameter int            NREQ           = 3,
  parameter int            AW             = 8,
  parameter int            DEPTH          = MAP_TILES,
  parameter int            DW             = TILE_W,
  parameter int            DISP_MAX_BURST = 4,
  parameter logic [DW-1:0] CLEAR_VAL      = DW'(TILE_EMPTY)
) (
  input  logic               sys_clk,
  input  logic               Reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  input  logic               disp_req,
  input  logic [AW-1:0]      disp_addr,
  output logic               disp_valid,
  output logic [DW-1:0]      disp_rdata,
  output logic               disp_stall,
  input  logic               clear_start,
  output logic               clear_busy
);

  localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          BW      = $clog2(DISP_MAX_BURST + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  arb_state_t      state, state_nxt;
  logic [AW-1:0]   clr_addr;
  logic [PW-1:0]   rr_ptr, pick;
  logic [BW-1:0]   burst_cnt;
  logic [NREQ-1:0] inflight, elig, game_gnt_vec, ack_q;
  logic            any_elig, found, disp_blocked, disp_gnt, game_gnt;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   gwdata;
  logic            gwe, g_in_range;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata, ram_q;
  logic            game_rd_q, oob_q, disp_valid_q;
  logic [DW-1:0]   rdata_hold, disp_hold;

  // A requester still holding req in its ack cycle must not be granted again.
  assign elig         = req & ~inflight;
  assign any_elig     = |elig;
  assign disp_blocked = (burst_cnt == BW'(DISP_MAX_BURST)) && any_elig;

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[PW'((int'(rr_ptr) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign gaddr      = addr[int'(pick)*AW +: AW];
  assign gwdata     = wdata[int'(pick)*DW +: DW];
  assign gwe        = we[pick];
  assign g_in_range = ({1'b0, gaddr} < DEPTH_W);

  always_comb begin
    state_nxt  = state;
    disp_gnt   = 1'b0;
    game_gnt   = 1'b0;
    disp_stall = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = disp_addr;
    ram_wdata  = CLEAR_VAL;
    case (state)
      ST_IDLE: begin
        if (clear_start) state_nxt = ST_CLEAR;
        if (disp_req && !disp_blocked) begin
          disp_gnt = 1'b1;
          ram_en   = 1'b1;
        end else if (any_elig) begin
          game_gnt  = 1'b1;
          ram_en    = 1'b1;
          ram_addr  = gaddr;
          ram_we    = gwe & g_in_range;
          ram_wdata = gwdata;
        end
        disp_stall = disp_req && disp_blocked;
      end
      ST_CLEAR: begin
        disp_stall = disp_req;
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = clr_addr;
        if (clr_addr == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    game_gnt_vec = '0;
    if (game_gnt) game_gnt_vec[pick] = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      clr_addr     <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      inflight     <= '0;
      ack_q        <= '0;
      game_rd_q    <= 1'b0;
      oob_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      rdata_hold   <= '0;
      disp_hold    <= '0;
    end else begin
      state        <= state_nxt;
      clr_addr     <= (state == ST_IDLE) ? '0 : clr_addr + 1'b1;
      inflight     <= game_gnt_vec;
      ack_q        <= game_gnt_vec;
      game_rd_q    <= game_gnt & ~gwe;
      oob_q        <= ~g_in_range;
      disp_valid_q <= disp_gnt;
      if (game_gnt) rr_ptr <= (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
      if (game_gnt || !any_elig)
        burst_cnt <= '0;
      else if (disp_gnt && burst_cnt != BW'(DISP_MAX_BURST))
        burst_cnt <= burst_cnt + 1'b1;
      if (game_rd_q)    rdata_hold <= rdata;
      if (disp_valid_q) disp_hold  <= disp_rdata;
    end
  end

  map_ram_arbiter_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .sys_clk (sys_clk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_q)
  );

  // Out-of-range game reads complete with CLEAR_VAL; outputs hold between completions.
  assign rdata      = game_rd_q ? (oob_q ? CLEAR_VAL : ram_q) : rdata_hold;
  assign disp_rdata = disp_valid_q ? ram_q : disp_hold;
  assign ack        = ack_q;
  assign disp_valid = disp_valid_q;
  assign clear_busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb/tb_map_ram_arbiter.sv - directed, table-driven bench for map_ram_arbiter

module tb_map_ram_arbiter;

  logic        sys_clk;
  logic        Reset;
  logic [2:0]  req, we, ack;
  logic [23:0] addr;
  logic [8:0]  wdata;
  logic [2:0]  rdata, disp_rdata;
  logic        disp_req, disp_valid, disp_stall, clear_start, clear_busy;
  logic [7:0]  disp_addr;

  int checks   = 0;
  int failures = 0;

  map_ram_arbiter dut (
    .sys_clk     (sys_clk),
    .Reset       (Reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_rdata  (disp_rdata),
    .disp_stall  (disp_stall),
    .clear_start (clear_start),
    .clear_busy  (clear_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [8:0]  wdata;
    logic        dreq;
    logic [7:0]  daddr;
    logic [2:0]  eack;
    logic        edv;
    logic        est;
    int          erd;   // -1: not checked
    int          edrd;  // -1: not checked
  } vec_t;

  vec_t vecs[30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string n, input logic [2:0] r, input logic [2:0] w,
                               input logic [23:0] a, input logic [8:0] d, input logic dr,
                               input logic [7:0] da, input logic [2:0] eack, input logic edv,
                               input logic est, input int erd, input int edrd);
    vec_t v;
    v.name = n; v.req = r; v.we = w; v.addr = a; v.wdata = d; v.dreq = dr; v.daddr = da;
    v.eack = eack; v.edv = edv; v.est = est; v.erd = erd; v.edrd = edrd;
    return v;
  endfunction

  function automatic logic [23:0] pa(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [8:0] pd(input int d0, input int d1, input int d2);
    return {3'(d2), 3'(d1), 3'(d0)};
  endfunction

  // Entered at a cycle start (posedge+2); returns in the ack cycle with req dropped.
  task automatic do_access(input int i, input logic w, input logic [7:0] a,
                           input logic [2:0] d, output logic [2:0] rd);
    int   n;
    logic got;
    req[i] = 1'b1; we[i] = w; addr[i*8 +: 8] = a; wdata[i*3 +: 3] = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge sys_clk); #2;
      if (ack[i]) got = 1'b1;
      else n++;
    end
    rd = rdata;
    req[i] = 1'b0;
    check($sformatf("access_ack_r%0d_a%0d", i, a), 32'(got), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},        32'(ack),        32'd0);
    check({tag, "_rdata"},      32'(rdata),      32'd0);
    check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    check({tag, "_disp_rdata"}, 32'(disp_rdata), 32'd0);
    check({tag, "_disp_stall"}, 32'(disp_stall), 32'd0);
    check({tag, "_clear_busy"}, 32'(clear_busy), 32'd0);
  endtask

  initial begin
    logic [2:0] rd;
    int         busy_cnt;
    logic       ack_seen, lost;

    vecs[0]  = mkv("t2_wr_grant",   3'b001, 3'b001, pa(17,0,0),  pd(2,0,0), 0, 0,  3'b000, 0, 0, -1, -1);
    vecs[1]  = mkv("t2_wr_ack",     3'b000, 3'b000, pa(17,0,0),  pd(2,0,0), 0, 0,  3'b001, 0, 0, -1, -1);
    vecs[2]  = mkv("t2_rd_grant",   3'b001, 3'b000, pa(17,0,0),  pd(0,0,0), 0, 0,  3'b000, 0, 0, -1, -1);
    vecs[3]  = mkv("t2_rd_ack",     3'b000, 3'b000, pa(17,0,0),  pd(0,0,0), 0, 0,  3'b001, 0, 0,  2, -1);
    vecs[4]  = mkv("b2b_wr",        3'b010, 3'b010, pa(0,20,0),  pd(0,5,0), 0, 0,  3'b000, 0, 0, -1, -1);
    vecs[5]  = mkv("b2b_rd",        3'b001, 3'b000, pa(20,20,0), pd(0,0,0), 0, 0,  3'b010, 0, 0, -1, -1);
    vecs[6]  = mkv("b2b_rd_ack",    3'b000, 3'b000, pa(20,20,0), pd(0,0,0), 0, 0,  3'b001, 0, 0,  5, -1);
    vecs[7]  = mkv("oob_wr",        3'b100, 3'b100, pa(0,0,200), pd(0,0,7), 0, 0,  3'b000, 0, 0, -1, -1);
    vecs[8]  = mkv("oob_wr_ack",    3'b000, 3'b000, pa(0,0,200), pd(0,0,7), 0, 0,  3'b100, 0, 0,  5, -1);
    vecs[9]  = mkv("oob_rd",        3'b100, 3'b000, pa(0,0,200), pd(0,0,0), 0, 0,  3'b000, 0, 0, -1, -1);
    vecs[10] = mkv("oob_rd_ack",    3'b000, 3'b000, pa(0,0,200), pd(0,0,0), 0, 0,  3'b100, 0, 0,  0, -1);
    vecs[11] = mkv("rr_g0",         3'b111, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b000, 0, 0, -1, -1);
    vecs[12] = mkv("rr_g1",         3'b111, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b001, 0, 0,  2, -1);
    vecs[13] = mkv("rr_g2",         3'b111, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b010, 0, 0,  5, -1);
    vecs[14] = mkv("rr_g0b",        3'b111, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b100, 0, 0,  0, -1);
    vecs[15] = mkv("rr_g1b",        3'b111, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b001, 0, 0,  2, -1);
    vecs[16] = mkv("rr_g2b",        3'b111, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b010, 0, 0,  5, -1);
    vecs[17] = mkv("rr_tail",       3'b000, 3'b000, pa(17,20,0), pd(0,0,0), 0, 0,  3'b100, 0, 0,  0, -1);
    vecs[18] = mkv("same_disp",     3'b100, 3'b000, pa(0,0,17),  pd(0,0,0), 1, 20, 3'b000, 0, 0, -1, -1);
    vecs[19] = mkv("same_dv",       3'b100, 3'b000, pa(0,0,17),  pd(0,0,0), 0, 0,  3'b000, 1, 0, -1,  5);
    vecs[20] = mkv("same_ack2",     3'b000, 3'b000, pa(0,0,17),  pd(0,0,0), 0, 0,  3'b100, 0, 0,  2, -1);
    vecs[21] = mkv("burst_d1",      3'b010, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b000, 0, 0, -1, -1);
    vecs[22] = mkv("burst_d2",      3'b010, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b000, 1, 0, -1,  2);
    vecs[23] = mkv("burst_d3",      3'b010, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b000, 1, 0, -1,  2);
    vecs[24] = mkv("burst_d4",      3'b010, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b000, 1, 0, -1,  2);
    vecs[25] = mkv("burst_stall",   3'b010, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b000, 1, 1, -1,  2);
    vecs[26] = mkv("burst_ack1",    3'b000, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b010, 0, 0,  5, -1);
    vecs[27] = mkv("burst_resume",  3'b000, 3'b000, pa(0,20,0),  pd(0,0,0), 1, 17, 3'b000, 1, 0,  5,  2);
    vecs[28] = mkv("burst_tail",    3'b000, 3'b000, pa(0,20,0),  pd(0,0,0), 0, 0,  3'b000, 1, 0,  5,  2);
    vecs[29] = mkv("idle_hold",     3'b000, 3'b000, pa(0,20,0),  pd(0,0,0), 0, 0,  3'b000, 0, 0,  5, -1);

    Reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    disp_req = 1'b0; disp_addr = '0; clear_start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    check_all_zero("reset");
    Reset = 1'b0;
    @(posedge sys_clk); #2;

    // Pre-fill, then clear; the clear must overwrite them.
    do_access(0, 1'b1, 8'd0,   3'd3, rd);
    do_access(0, 1'b1, 8'd100, 3'd4, rd);
    do_access(0, 1'b1, 8'd194, 3'd2, rd);
    clear_start = 1'b1;
    #1;
    check("busy_before_start", 32'(clear_busy), 32'd0);
    @(posedge sys_clk); #2;
    clear_start = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[15:8] = 8'd100;
    busy_cnt = 0; ack_seen = 1'b0;
    while (clear_busy && busy_cnt < 400) begin
      busy_cnt++;
      if (ack != 3'b000) ack_seen = 1'b1;
      if (busy_cnt == 10) begin
        disp_req = 1'b1; disp_addr = 8'd5; clear_start = 1'b1;
        #1;
        check("clear_disp_stall", 32'(disp_stall), 32'd1);
      end else begin
        disp_req = 1'b0; clear_start = 1'b0;
      end
      if (busy_cnt == 11) check("clear_disp_valid", 32'(disp_valid), 32'd0);
      @(posedge sys_clk); #2;
    end
    check("clear_busy_cycles", 32'(busy_cnt), 32'd195);
    check("no_ack_during_clear", 32'(ack_seen), 32'd0);
    @(posedge sys_clk); #2;
    check("pending_ack_after_clear", 32'(ack), 32'b010);
    check("clear_rd100", 32'(rdata), 32'd0);
    req[1] = 1'b0;
    do_access(0, 1'b0, 8'd0, 3'd0, rd);
    check("clear_rd0", 32'(rd), 32'd0);
    do_access(0, 1'b0, 8'd194, 3'd0, rd);
    check("clear_rd194", 32'(rd), 32'd0);
    @(posedge sys_clk); #2;

    for (int i = 0; i < 30; i++) begin
      req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      disp_req = vecs[i].dreq; disp_addr = vecs[i].daddr;
      #1;
      check({vecs[i].name, "_ack"},   32'(ack),        32'(vecs[i].eack));
      check({vecs[i].name, "_dv"},    32'(disp_valid), 32'(vecs[i].edv));
      check({vecs[i].name, "_stall"}, 32'(disp_stall), 32'(vecs[i].est));
      if (vecs[i].erd >= 0)  check({vecs[i].name, "_rdata"}, 32'(rdata),      32'(vecs[i].erd));
      if (vecs[i].edrd >= 0) check({vecs[i].name, "_drdata"}, 32'(disp_rdata), 32'(vecs[i].edrd));
      @(posedge sys_clk); #2;
    end

    // Reset while the clear is writing address 50.
    do_access(0, 1'b1, 8'd60, 3'd4, rd);
    do_access(0, 1'b1, 8'd40, 3'd3, rd);
    clear_start = 1'b1;
    @(posedge sys_clk); #2;
    clear_start = 1'b0;
    disp_req = 1'b1; disp_addr = 8'd1;
    lost = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) begin
        @(posedge sys_clk); #2;
      end
      if (!clear_busy) lost = 1'b1;
    end
    check("abort_busy_held", 32'(lost), 32'd0);
    #1;
    check("abort_pre_stall", 32'(disp_stall), 32'd1);
    check("abort_pre_rdata", 32'(rdata), 32'd5);
    Reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge sys_clk);
    @(posedge sys_clk); #2;
    Reset = 1'b0; disp_req = 1'b0;
    @(posedge sys_clk); #2;
    do_access(2, 1'b0, 8'd60, 3'd0, rd);
    check("abort_addr60_kept", 32'(rd), 32'd4);
    do_access(1, 1'b0, 8'd40, 3'd0, rd);
    check("abort_addr40_cleared", 32'(rd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
